regfile_wb_port: RTL

- Write-side front end for the general-purpose register file. Merges single-cycle pipeline writebacks with late results (load returns, multi-cycle mul/div) onto the register file's single write port (we/waddr/wdata).
- Late results wait in a small FIFO. A per-register pending scoreboard gives decode a busy mask for RAW/WAW stalls.
- Sits between the MEM/WB stage and the register file.

---
 rtl/regfile_wb_port_pkg.sv | 23 ++
 rtl/regfile_wb_port_late_fifo.sv | 84 ++++++++
 rtl/regfile_wb_port.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_port_pkg.sv
// Shared definitions for the register-file write-side front end.
//
// Contents:
//   DATA_W_DEF / ADDR_W_DEF / DEPTH_DEF  default widths and late-FIFO depth
//   write_enable_e                       encoding of the registered write enable
//   is_pow2()                            helper used to sanity-check DEPTH

package regfile_wb_port_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned ADDR_W_DEF = 5;
   localparam int unsigned DEPTH_DEF  = 2;

   typedef enum logic {
      WE_OFF = 1'b0,
      WE_ON  = 1'b1
   } write_enable_e;

   function automatic bit is_pow2(input int unsigned val);
      return (val != 0) && ((val & (val - 1)) == 0);
   endfunction

endpackage

// File: rtl/regfile_wb_port_late_fifo.sv
// wb_late_fifo: synchronous FIFO holding late results ({waddr, wdata})
// until the register file write port is free.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset (empties the FIFO)
//   push_i          enqueue push_data_i (ignored while full)
//   push_data_i     payload to enqueue
//   pop_i           dequeue the head (ignored while empty)
//   head_o          current head payload (valid while !empty_o)
//   full_o          DEPTH entries held
//   empty_o         no entries held
//
// DEPTH must be a power of two so the pointers wrap naturally.

module wb_late_fifo
   import regfile_wb_port_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEF,
   parameter int unsigned WIDTH = ADDR_W_DEF + DATA_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_ptr_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only read once counted in.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

endmodule

// File: rtl/regfile_wb_port.sv
// regfile_wb_port: write-side front end of the general-purpose register file.
// Merges single-cycle pipeline writebacks with late results (loads, mul/div)
// onto the single register-file write port, and keeps a per-register pending
// scoreboard for decode stalls.
//
// Ports:
//   clk, rst                               clock, synchronous active-high reset
//   pipe_we/pipe_waddr/pipe_wdata          pipeline writeback (no backpressure)
//   late_valid/late_ready/late_waddr/
//   late_wdata                             late result handshake
//   issue_valid/issue_waddr                decode issued a late-producing op
//   rf_we/rf_waddr/rf_wdata                registered register-file write port
//   busy_mask                              bit r set: late write to r pending
//   sb_conflict                            one-cycle pulse: issue to busy reg
//
// Build option:
//   WB_BYPASS_EN  when defined, a late result accepted while the FIFO is empty
//                 and the pipe is idle goes straight to the write port,
//                 saving one cycle. Priority is unchanged.
//
// Register 0 is hardwired: never written, never busy.

module regfile_wb_port
   import regfile_wb_port_pkg::*;
#(
   parameter int unsigned DEPTH  = DEPTH_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pipe_we,
   input  logic [ADDR_W-1:0]    pipe_waddr,
   input  logic [DATA_W-1:0]    pipe_wdata,
   input  logic                 late_valid,
   output logic                 late_ready,
   input  logic [ADDR_W-1:0]    late_waddr,
   input  logic [DATA_W-1:0]    late_wdata,
   input  logic                 issue_valid,
   input  logic [ADDR_W-1:0]    issue_waddr,
   output logic                 rf_we,
   output logic [ADDR_W-1:0]    rf_waddr,
   output logic [DATA_W-1:0]    rf_wdata,
   output logic [2**ADDR_W-1:0] busy_mask,
   output logic                 sb_conflict
);

   localparam int unsigned NREG    = 2 ** ADDR_W;
   localparam int unsigned ENTRY_W = ADDR_W + DATA_W;

   write_enable_e       rf_we_q, rf_we_d;
   logic [ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
   logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
   logic [NREG-1:0]     busy_q, busy_d;
   logic                conflict_q, conflict_d;

   logic                pipe_act;
   logic                late_acc;
   logic                late_live;
   logic                issue_live;
   logic                bypass;
   logic                fifo_push;
   logic                fifo_pop;
   logic                fifo_full;
   logic                fifo_empty;
   logic [ENTRY_W-1:0]  fifo_head;
   logic [ADDR_W-1:0]   head_waddr;
   logic [DATA_W-1:0]   head_wdata;
   logic                late_wr;
   logic [ADDR_W-1:0]   late_wr_addr;

   // ------------------------------------------------------------------
   // Input qualification
   // ------------------------------------------------------------------
   assign pipe_act   = pipe_we && (pipe_waddr != '0);
   assign late_ready = !fifo_full;
   assign late_acc   = late_valid && !fifo_full;
   // A late result for r0 is still handshaken but simply discarded.
   assign late_live  = late_acc && (late_waddr != '0);
   assign issue_live = issue_valid && (issue_waddr != '0);

`ifdef WB_BYPASS_EN
   assign bypass = late_live && fifo_empty && !pipe_act;
`else
   assign bypass = 1'b0;
`endif

   assign fifo_push = late_live && !bypass;
   // Pipe writes have absolute priority; the head only drains in idle slots.
   assign fifo_pop  = !pipe_act && !fifo_empty;

   assign {head_waddr, head_wdata} = fifo_head;

   wb_late_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_late_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (fifo_push),
      .push_data_i ({late_waddr, late_wdata}),
      .pop_i       (fifo_pop),
      .head_o      (fifo_head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   // ------------------------------------------------------------------
   // Write-port arbitration
   // ------------------------------------------------------------------
   always_comb begin
      rf_we_d      = WE_OFF;
      rf_waddr_d   = rf_waddr_q;
      rf_wdata_d   = rf_wdata_q;
      late_wr      = 1'b0;
      late_wr_addr = '0;
      if (pipe_act) begin
         rf_we_d    = WE_ON;
         rf_waddr_d = pipe_waddr;
         rf_wdata_d = pipe_wdata;
      end else if (fifo_pop) begin
         rf_we_d      = WE_ON;
         rf_waddr_d   = head_waddr;
         rf_wdata_d   = head_wdata;
         late_wr      = 1'b1;
         late_wr_addr = head_waddr;
      end else if (bypass) begin
         rf_we_d      = WE_ON;
         rf_waddr_d   = late_waddr;
         rf_wdata_d   = late_wdata;
         late_wr      = 1'b1;
         late_wr_addr = late_waddr;
      end
   end

   // ------------------------------------------------------------------
   // Pending scoreboard
   // ------------------------------------------------------------------
   // Clear happens on the edge that loads rf_*, so the bit is already low in
   // the cycle the write lands; the register file forwards that same cycle.
   // A new issue in the same cycle re-arms the bit (set after clear).
   always_comb begin
      busy_d     = busy_q;
      conflict_d = 1'b0;
      if (late_wr) begin
         busy_d[late_wr_addr] = 1'b0;
      end
      if (issue_live) begin
         conflict_d          = busy_q[issue_waddr];
         busy_d[issue_waddr] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we_q    <= WE_OFF;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         busy_q     <= '0;
         conflict_q <= 1'b0;
      end else begin
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         busy_q     <= busy_d;
         conflict_q <= conflict_d;
      end
   end

   assign rf_we       = (rf_we_q == WE_ON);
   assign rf_waddr    = rf_waddr_q;
   assign rf_wdata    = rf_wdata_q;
   assign busy_mask   = busy_q;
   assign sb_conflict = conflict_q;

endmodule
